// File: rtl/io_n_bidirectional_sync_filter_if.sv
// Fabric/pad signal bundle for io_n_bidirectional_sync_filter.
// slave: IO BEL side. master: switch matrix, pad buffers and config frame.
// I, T        : fabric data and tristate (1 = high-Z)
// O, Q        : raw and synchronised/filtered pad input to fabric
// Q_rise/fall : one-cycle edge pulses of Q
// I_top/T_top : data and output enable (1 = drive) to pad buffer
// O_top       : pad input
// ConfigBits  : 2 bits per channel (3 with IO_BIDIR_LOOPBACK_EN)
interface io_n_bidirectional_sync_filter_if #(
    parameter int CH = 4
);
`ifdef IO_BIDIR_LOOPBACK_EN
    localparam int CFG_W = 3 * CH;
`else
    localparam int CFG_W = 2 * CH;
`endif

    logic [CH-1:0]    I;
    logic [CH-1:0]    T;
    logic [CH-1:0]    O;
    logic [CH-1:0]    Q;
    logic [CH-1:0]    Q_rise;
    logic [CH-1:0]    Q_fall;
    logic [CH-1:0]    I_top;
    logic [CH-1:0]    T_top;
    logic [CH-1:0]    O_top;
    logic [CFG_W-1:0] ConfigBits;

    modport master (
        output I, T, O_top, ConfigBits,
        input  O, Q, Q_rise, Q_fall, I_top, T_top
    );

    modport slave (
        input  I, T, O_top, ConfigBits,
        output O, Q, Q_rise, Q_fall, I_top, T_top
    );
endinterface

// File: rtl/io_n_bidirectional_sync_filter.sv
// Multi-channel bidirectional IO BEL: optional registered output path,
// input synchroniser, optional glitch filter and rise/fall event pulses.
// Ports: UserCLK (rising edge), RST (async, active high),
//        bus (slave modport): I, T, O, Q, Q_rise, Q_fall, I_top, T_top,
//        O_top, ConfigBits (bit 2c = OUT_REG, bit 2c+1 = FILT_EN).
// Optional macro IO_BIDIR_LOOPBACK_EN adds LOOP at bit 2*CH+c: the
// channel reads back its own I_top and stops driving the pad.
module io_n_bidirectional_sync_filter #(
    parameter int CH            = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = $clog2(FILTER_CYCLES + 1)
) (
    input logic                             UserCLK,
    input logic                             RST,
    io_n_bidirectional_sync_filter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CH-1:0] out_reg;
    logic [CH-1:0] filt_en;
    logic [CH-1:0] i_reg;
    logic [CH-1:0] tn_reg;
    logic [CH-1:0] i_top;
    logic [CH-1:0] tn_top;
    logic [CH-1:0] pad_in;
    logic [CH-1:0] s_out;
    logic [CH-1:0] q_reg;
    logic [CH-1:0] q_prev;
    logic [CH-1:0] q_nxt;

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CH-1:0][CNT_W-1:0]       cnt_q;
    logic [CH-1:0][CNT_W-1:0]       cnt_nxt;

`ifdef IO_BIDIR_LOOPBACK_EN
    logic [CH-1:0] loop_en;
`endif

    always_comb begin
        out_reg = '0;
        filt_en = '0;
        s_out   = '0;
        for (int c = 0; c < CH; c++) begin
            out_reg[c] = bus.ConfigBits[2*c];
            filt_en[c] = bus.ConfigBits[2*c+1];
            s_out[c]   = sync_q[c][SYNC_STAGES-1];
        end
    end

    // Output registers always clock, so flipping OUT_REG never
    // exposes a value older than one cycle.
    assign i_top  = (out_reg & i_reg)  | (~out_reg & bus.I);
    assign tn_top = (out_reg & tn_reg) | (~out_reg & ~bus.T);

`ifdef IO_BIDIR_LOOPBACK_EN
    always_comb begin
        loop_en = '0;
        for (int c = 0; c < CH; c++) begin
            loop_en[c] = bus.ConfigBits[2*CH+c];
        end
    end

    assign pad_in    = (loop_en & i_top) | (~loop_en & bus.O_top);
    assign bus.T_top = tn_top & ~loop_en;
`else
    assign pad_in    = bus.O_top;
    assign bus.T_top = tn_top;
`endif

    assign bus.I_top = i_top;
    assign bus.O     = pad_in;

    // Filter: Q only follows s_out after FILTER_CYCLES consecutive
    // disagreeing cycles; any agreement restarts the count.
    always_comb begin
        q_nxt   = q_reg;
        cnt_nxt = '0;
        for (int c = 0; c < CH; c++) begin
            if (!filt_en[c]) begin
                q_nxt[c] = s_out[c];
            end else if (s_out[c] == q_reg[c]) begin
                cnt_nxt[c] = '0;
            end else if (cnt_q[c] == CNT_LAST) begin
                q_nxt[c] = s_out[c];
            end else begin
                cnt_nxt[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            i_reg  <= '0;
            tn_reg <= '0;
            sync_q <= '0;
            q_reg  <= '0;
            q_prev <= '0;
            cnt_q  <= '0;
        end else begin
            i_reg  <= bus.I;
            tn_reg <= ~bus.T;
            for (int c = 0; c < CH; c++) begin
                sync_q[c][0] <= pad_in[c];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[c][k] <= sync_q[c][k-1];
                end
            end
            q_reg  <= q_nxt;
            q_prev <= q_reg;
            cnt_q  <= cnt_nxt;
        end
    end

    assign bus.Q      = q_reg;
    assign bus.Q_rise = q_reg & ~q_prev;
    assign bus.Q_fall = ~q_reg & q_prev;

endmodule

// File: tb/tb_io_n_bidirectional_sync_filter.sv
// Self-checking bench for io_n_bidirectional_sync_filter: directed
// scenarios plus randomized traffic against a behavioural model.
module tb_io_n_bidirectional_sync_filter;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FC = 4;
`ifdef IO_BIDIR_LOOPBACK_EN
    localparam int CFG_W = 3 * CH;
`else
    localparam int CFG_W = 2 * CH;
`endif

    logic UserCLK = 1'b0;
    logic RST;

    always #5 UserCLK = ~UserCLK;

    io_n_bidirectional_sync_filter_if #(.CH(CH)) bus ();

    io_n_bidirectional_sync_filter #(
        .CH           (CH),
        .SYNC_STAGES  (SS),
        .FILTER_CYCLES(FC)
    ) dut (
        .UserCLK(UserCLK),
        .RST    (RST),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [CH-1:0] q_m, prev_m, ireg_m, tnreg_m;
    int            streak [CH];
    logic [CH-1:0] hist [$];

    task automatic chk(input string tag, input logic [CH-1:0] obs,
                       input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] cfg_field(input int base,
                                                input int stride);
        logic [CH-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c] = bus.ConfigBits[base+stride*c];
        return r;
    endfunction

    function automatic logic [CH-1:0] loop_v();
`ifdef IO_BIDIR_LOOPBACK_EN
        return cfg_field(2 * CH, 1);
`else
        return '0;
`endif
    endfunction

    task automatic expect_comb(output logic [CH-1:0] itop,
                               output logic [CH-1:0] ttop,
                               output logic [CH-1:0] pad);
        logic [CH-1:0] orv, lp;
        orv  = cfg_field(0, 2);
        lp   = loop_v();
        itop = orv ? '0 : '0;
        for (int c = 0; c < CH; c++) begin
            itop[c] = orv[c] ? ireg_m[c] : bus.I[c];
            ttop[c] = (orv[c] ? tnreg_m[c] : ~bus.T[c]) & ~lp[c];
            pad[c]  = lp[c] ? itop[c] : bus.O_top[c];
        end
    endtask

    task automatic model_reset();
        q_m = '0; prev_m = '0; ireg_m = '0; tnreg_m = '0;
        for (int c = 0; c < CH; c++) streak[c] = 0;
        hist.delete();
    endtask

    task automatic check_all();
        logic [CH-1:0] itop, ttop, pad;
        expect_comb(itop, ttop, pad);
        chk("I_top", bus.I_top, itop);
        chk("T_top", bus.T_top, ttop);
        chk("O", bus.O, pad);
        chk("Q", bus.Q, q_m);
        chk("Q_rise", bus.Q_rise, q_m & ~prev_m);
        chk("Q_fall", bus.Q_fall, ~q_m & prev_m);
    endtask

    // One clock: check settled inputs, advance model and DUT, recheck.
    task automatic tick();
        logic [CH-1:0] itop, ttop, pad, sout, nq, filt, i_s, tn_s;
        int            nstreak [CH];
        #1;
        check_all();
        expect_comb(itop, ttop, pad);
        filt = cfg_field(1, 2);
        sout = (hist.size() >= SS) ? hist[SS-1] : '0;
        nq   = q_m;
        i_s  = bus.I;
        tn_s = ~bus.T;
        for (int c = 0; c < CH; c++) begin
            nstreak[c] = 0;
            if (!filt[c]) nq[c] = sout[c];
            else if (sout[c] != q_m[c]) begin
                if (streak[c] + 1 >= FC) nq[c] = sout[c];
                else nstreak[c] = streak[c] + 1;
            end
        end
        @(posedge UserCLK);
        if (RST) begin
            model_reset();
        end else begin
            prev_m  = q_m;
            q_m     = nq;
            ireg_m  = i_s;
            tnreg_m = tn_s;
            for (int c = 0; c < CH; c++) streak[c] = nstreak[c];
            hist.push_front(pad);
            while (hist.size() > SS) void'(hist.pop_back());
        end
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("rst_q", bus.Q, '0);
        chk("rst_no_fall", bus.Q_fall, '0);
        check_all();
        #1;
        RST = 1'b0;
    endtask

    int rises;

    initial begin
        RST            = 1'b1;
        bus.I          = '1;
        bus.T          = '0;
        bus.O_top      = '1;
        bus.ConfigBits = '0;
        for (int c = 0; c < CH; c++) bus.ConfigBits[2*c] = 1'b1;
        model_reset();

        // Reset holds everything low even with an active pad
        tick();
        tick();
        chk("rst_T_top", bus.T_top, '0);
        chk("rst_Q", bus.Q, '0);
        RST = 1'b0;
        tick();
        chk("post_rst_e1", bus.Q, '0);
        tick();
        chk("post_rst_e2", bus.Q, '0);
        tick();
        chk("post_rst_e3", bus.Q, '1);
        chk("post_rst_rise", bus.Q_rise, '1);
        tick();
        chk("post_rst_rise_end", bus.Q_rise, '0);

        // Output path: combinational then registered
        bus.ConfigBits = '0;
        bus.I          = '0;
        tick();
        bus.I = '1;
        #1;
        chk("comb_I_top", bus.I_top, '1);
        chk("comb_T_top", bus.T_top, '1);
        for (int c = 0; c < CH; c++) bus.ConfigBits[2*c] = 1'b1;
        bus.I = '0;
        tick();
        bus.I = '1;
        tick();
        chk("reg_I_top", bus.I_top, '1);

        // Glitch reject with filter on
        bus.ConfigBits = '0;
        for (int c = 0; c < CH; c++) bus.ConfigBits[2*c+1] = 1'b1;
        bus.O_top = '0;
        for (int k = 0; k < 8; k++) tick();
        chk("flt_settle", bus.Q, '0);
        rises     = 0;
        bus.O_top = '1;
        for (int k = 0; k < 3; k++) begin
            tick();
            rises += $countones(bus.Q_rise);
        end
        bus.O_top = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            rises += $countones(bus.Q_rise);
        end
        chk("glitch_q", bus.Q, '0);
        chk("glitch_rises", CH'(rises), '0);

        // Long pulse passes 4 cycles after s_out rises
        bus.O_top = '1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("flt_pass", bus.Q, (k >= 6) ? '1 : '0);
        end

        // Clear FILT_EN mid-count: Q follows s_out on the next edge
        bus.O_top = '0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_q_hold", bus.Q, '1);
        bus.ConfigBits = '0;
        tick();
        chk("mid_q_follow", bus.Q, '0);
        chk("mid_fall", bus.Q_fall, '1);

        // Async reset while the filter counts down from Q=1
        bus.O_top = '1;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_q", bus.Q, '1);
        for (int c = 0; c < CH; c++) bus.ConfigBits[2*c+1] = 1'b1;
        bus.O_top = '0;
        for (int k = 0; k < 4; k++) tick();
        async_reset();
        tick();

`ifdef IO_BIDIR_LOOPBACK_EN
        async_reset();
        bus.ConfigBits = '0;
        for (int c = 0; c < CH; c++) bus.ConfigBits[2*CH+c] = 1'b1;
        bus.I     = '1;
        bus.T     = '0;
        bus.O_top = '0;
        #1;
        chk("loop_O", bus.O, '1);
        chk("loop_T_top", bus.T_top, '0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("loop_Q", bus.Q, (k == 3) ? '1 : '0);
        end
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.O_top = bus.O_top ^ (CH'($urandom) & CH'($urandom)
                                     & CH'($urandom));
            bus.I = CH'($urandom);
            bus.T = CH'($urandom);
            if ($urandom_range(0, 19) == 0) bus.ConfigBits = CFG_W'($urandom);
            if ($urandom_range(0, 99) == 0) async_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
